mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-serial RAM controller. Arbitrates the single 8-bit RAM port between the instruction-fetch stage (word reads) and the memory-access stage (byte/half/word loads and stores).
- Sits directly upstream of the fetch stage: it supplies the fetched word, the done strobe and the busy/stall indication that fetch consumes.
- RAM model: the address is presented in cycle t and read data is valid on ram_data_i in cycle t+1. Writes complete in the cycle ram_wr_o is high.

Parameters:
- ADDR_W, 32, width of all addresses; address arithmetic wraps mod 2^ADDR_W.
- DATA_PRIO, 1. 1: the data side wins simultaneous requests. 0: the fetch side wins.

Ports:
- clk  in  1  single system clock, posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state and outputs.
- if_req_i  in  1  fetch request (level, held until if_done_o).
- if_addr_i  in  ADDR_W  fetch byte address, any alignment.
- if_data_o  out  32  fetched word, little-endian.
- if_done_o  out  1  1-cycle pulse; if_data_o valid in that cycle.
- mem_req_i  in  1  data request (level, held until mem_done_o).
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_addr_i  in  ADDR_W  data byte address.
- mem_wdata_i  in  32  store data; low N bytes used.
- mem_rdata_o  out  32  load data, zero-extended (sign extension is done by the memory-access stage).
- mem_done_o  out  1  1-cycle pulse on completion.
- busy_o  out  1  high whenever state != IDLE; the fetch stage uses it as its RAM stall.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write enable.
- ram_data_o  out  8  RAM write byte.
- ram_data_i  in  8  RAM read byte.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, byte counter 0. ram_wr_o drops immediately. Any in-flight transfer is discarded with no done pulse. A store is left partially written; this is acceptable.
- rdy low: every register holds, including the counter, state and outputs. Operation resumes exactly where it stopped.
- State machine: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE, no request: ram_wr_o = 0; ram_addr_o holds its last value.
- IDLE with a request: the winner is chosen per DATA_PRIO; the loser waits.
  - Set N: 4 for fetch; 1, 2 or 4 from mem_size_i for data.
  - Latch addr, N, we and wdata.
  - ram_addr_o <= addr; cnt <= 0.
  - Store: ram_wr_o <= 1, ram_data_o <= wdata[7:0], go to WRITE.
  - Otherwise: go to READ.
- READ, each edge:
  - If cnt >= 1: result byte[cnt-1] <= ram_data_i.
  - If cnt < N-1: ram_addr_o <= ram_addr_o + 1.
  - cnt <= cnt + 1.
  - When cnt == N: drive the done pulse of the owning side, drive if_data_o or mem_rdata_o (unwritten bytes = 0), go to DONE.
  - Accept-to-done latency: N+1 cycles (fetch word: 5 cycles).
- WRITE, each edge:
  - If cnt < N-1: ram_addr_o += 1, ram_data_o <= wdata byte cnt+1, ram_wr_o stays 1, cnt += 1.
  - Else: ram_wr_o <= 0, mem_done_o <= 1, go to DONE.
  - ram_wr_o is high for exactly N cycles.
- DONE: lasts exactly one cycle. The done pulse is visible in this cycle. No request is accepted in this cycle; the requester drops its req on seeing done. Next state is IDLE.
- Requests are not preempted. A data request arriving during a fetch waits until the fetch completes, and vice versa. Effective request attributes are the ones latched at acceptance; changes to the inputs mid-transfer are ignored.
- Address wrap: address 2^ADDR_W - 1 followed by +1 gives 0; no error is raised.
- if_data_o and mem_rdata_o hold their values until the next completion on the same side.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,00,00,93; if_req at 0x100 -> ram_addr_o sequence 0x100..0x103, if_done_o 5 cycles after accept, if_data_o = 0x93000013, busy_o high for 6 cycles.
- Store word 0xDEADBEEF at 0x2000 -> ram_wr_o high 4 cycles with bytes EF,BE,AD,DE at 0x2000..0x2003; mem_done_o pulse; then a load half at 0x2002 -> mem_rdata_o = 0x0000DEAD, done 3 cycles after accept.
- if_req and mem_req (load byte at 0x10, RAM = 0x80) rise together with DATA_PRIO = 1 -> data served first, mem_rdata_o = 0x00000080; the fetch is accepted on the first IDLE edge after DONE; no byte is corrupted.
- rdy low for 3 cycles mid-fetch after byte 1 -> outputs frozen; the final word is correct and latency is extended by exactly 3 cycles.
- rst_n low mid-store after 2 bytes -> ram_wr_o is 0 asynchronously, no mem_done_o, all outputs 0. A new fetch after reset release completes normally.
- Word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1; result assembled little-endian.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: one 8-bit RAM port shared between instruction
// fetch (word reads) and the memory-access stage (byte/half/word loads and stores).
module mem_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_PRIO = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_size_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_data_o,
   input  logic [7:0]        ram_data_i
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [2:0]  num;
   logic        owner_data;
   logic [31:0] wdata;
   logic [31:0] rbuf;
   logic        stalled;
   logic [7:0]  hold_byte;
   logic        take_data;
   logic        take_fetch;
   logic [7:0]  rd_byte;
   logic [7:0]  next_byte;
   logic [31:0] merged;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // After a stall the RAM already shows the byte for the held address, so the
   // byte that was on the bus at the first frozen edge is replayed instead.
   always_comb begin
      take_data  = mem_req_i && ((DATA_PRIO != 0) || !if_req_i);
      take_fetch = if_req_i && !take_data;
      rd_byte    = stalled ? hold_byte : ram_data_i;
      merged     = rbuf;
      case (cnt)
         3'd1:    merged[7:0]   = rd_byte;
         3'd2:    merged[15:8]  = rd_byte;
         3'd3:    merged[23:16] = rd_byte;
         3'd4:    merged[31:24] = rd_byte;
         default: ;
      endcase
      case (cnt)
         3'd0:    next_byte = wdata[15:8];
         3'd1:    next_byte = wdata[23:16];
         default: next_byte = wdata[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         num         <= 3'd0;
         owner_data  <= 1'b0;
         wdata       <= 32'd0;
         rbuf        <= 32'd0;
         stalled     <= 1'b0;
         hold_byte   <= 8'd0;
         if_data_o   <= 32'd0;
         if_done_o   <= 1'b0;
         mem_rdata_o <= 32'd0;
         mem_done_o  <= 1'b0;
         busy_o      <= 1'b0;
         ram_addr_o  <= '0;
         ram_wr_o    <= 1'b0;
         ram_data_o  <= 8'd0;
      end else begin
         stalled <= !rdy;
         if (!rdy && !stalled)
            hold_byte <= ram_data_i;
         if (rdy) begin
            case (state)
               IDLE: begin
                  if (take_data || take_fetch) begin
                     owner_data <= take_data;
                     num        <= take_data ? size_bytes(mem_size_i) : 3'd4;
                     ram_addr_o <= take_data ? mem_addr_i : if_addr_i;
                     wdata      <= mem_wdata_i;
                     rbuf       <= 32'd0;
                     cnt        <= 3'd0;
                     busy_o     <= 1'b1;
                     if (take_data && mem_we_i) begin
                        ram_wr_o   <= 1'b1;
                        ram_data_o <= mem_wdata_i[7:0];
                        state      <= WRITE;
                     end else begin
                        state <= READ;
                     end
                  end
               end
               READ: begin
                  rbuf <= merged;
                  if (cnt < num - 3'd1)
                     ram_addr_o <= ram_addr_o + ADDR_W'(1);
                  cnt <= cnt + 3'd1;
                  if (cnt == num) begin
                     if (owner_data) begin
                        mem_rdata_o <= merged;
                        mem_done_o  <= 1'b1;
                     end else begin
                        if_data_o <= merged;
                        if_done_o <= 1'b1;
                     end
                     state <= DONE;
                  end
               end
               WRITE: begin
                  if (cnt < num - 3'd1) begin
                     ram_addr_o <= ram_addr_o + ADDR_W'(1);
                     ram_data_o <= next_byte;
                     cnt        <= cnt + 3'd1;
                  end else begin
                     ram_wr_o   <= 1'b0;
                     mem_done_o <= 1'b1;
                     state      <= DONE;
                  end
               end
               default: begin
                  if_done_o  <= 1'b0;
                  mem_done_o <= 1'b0;
                  busy_o     <= 1'b0;
                  state      <= IDLE;
               end
            endcase
         end
      end
   end
endmodule
